e_mdu: RTL and testbench
========================

# e_mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It sits beside the E-stage ALU and takes the same forwarded operands A and B. It runs mult/multu/div/divu as a multi-cycle operation behind a Start/Busy handshake, holds the architectural HI/LO registers, and returns HI or LO to the E-stage result mux for mfhi/mflo. The hazard unit stalls D while `Start | Busy` is high and the instruction in D uses the MDU.

## Interface
- `MULT_CYCLES`, 5: number of Busy cycles for mult/multu (and madd/maddu).
- `DIV_CYCLES`, 10: number of Busy cycles for div/divu.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled at the rising edge of `clk`).
- `A`  in  32  forwarded rs operand.
- `B`  in  32  forwarded rt operand.
- `MDUOp`  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu; all other codes are none.
- `Start`  in  1  one-cycle pulse, high while a mult/div/madd-class op is in E.
- `Busy`  out  1  high while an operation is in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.
- `MDUOut`  out  32  combinational read: HI for mfhi, LO for mflo, otherwise 0.

## Operation
- States are IDLE and RUN. The state is encoded by `Busy`, backed by a down-counter `cnt`.
- IDLE with `Start`=1 and `MDUOp` a mult/div-class op:
  - Compute the full result into temp registers `tHI`/`tLO`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Set `Busy`=1.
- Results written to `tHI`/`tLO`:
  - mult: signed 64-bit product, `{tHI,tLO}` = $signed(A)*$signed(B).
  - multu: unsigned 64-bit product.
  - div: `tLO` = quotient, `tHI` = remainder, signed, truncating toward zero; the remainder takes the sign of the dividend.
  - divu: unsigned quotient/remainder.
- RUN: decrement `cnt` each cycle. On the edge where `cnt`==1, commit `HI`<=`tHI`, `LO`<=`tLO` and clear `Busy`.
- Divide by zero (`B`==0, div or divu): Busy timing is unchanged and HI/LO are left unchanged at commit.
- `Start` while `Busy`=1 is ignored; the hazard unit guarantees it does not happen.
- mthi/mtlo with `Busy`=0: `HI`<=`A` (or `LO`<=`A`) at the next edge, with no Busy. With `Busy`=1 they are ignored.
- mfhi/mflo: `MDUOut` reflects the current `HI`/`LO` combinationally. During Busy it shows the old values; the stall covers this.
- `Start` with a non-mult/div op code is ignored.
- Reset (`reset`=0 at an edge) clears `HI`, `LO`, `tHI`, `tLO`, `cnt` and `Busy`, and discards any in-flight op.

## Timing
- Start sampled at edge t0. `Busy`=1 during cycles t0+1 … t0+N (N = 5 or 10). New HI/LO and `Busy`=0 are visible from cycle t0+N+1.
- A back-to-back Start is accepted in the first cycle with `Busy`=0.
- mthi/mtlo latency: 1 edge.
- `MDUOut` latency: 0 (combinational).
- Reset values of every output:
  - `Busy`=0, `HI`=0, `LO`=0.
  - `MDUOut`=0 for any non-mf op.

## Configuration
- Macro `MDU_MADD_EN` compiles in madd/maddu.
- Defined:
  - op 9 computes `{tHI,tLO}` = `{HI,LO}` + $signed(A)*$signed(B).
  - op 10 does the same with unsigned operands.
  - Both use `MULT_CYCLES`; the accumulator base is the HI/LO value at the Start edge.
- Undefined: ops 9/10 are treated as none. Start is ignored, Busy stays 0 and HI/LO are unchanged.

## Test plan
- mult with A=0xFFFFFFFF, B=2, Start pulse → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (−7), B=2 → Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 → LO=3, HI=1.
- mthi with A=0x12345678, then mfhi next cycle → MDUOut=0x12345678, Busy never asserts. Then div with B=0 → Busy 10 cycles, HI/LO unchanged.
- Start mult, then pulse Start div in cycle t0+2 → second Start ignored, HI/LO hold the mult result at t0+6. mtlo issued during Busy → LO unchanged.
- Start divu, then `reset`=0 at t0+3 → Busy=0, HI=LO=0 next cycle, and no commit occurs at t0+11.
- With `MDU_MADD_EN` defined: HI=0, LO=0xFFFFFFFF, madd with A=1, B=1 → HI=1, LO=0 after 5 cycles. Without the macro → Busy stays 0 and HI/LO unchanged.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with architectural HI/LO registers.
// Ops run behind a Start/Busy handshake; results are held in tHI/tLO until
// the final Busy cycle and committed together.
// Optional feature: define MDU_MADD_EN to compile in madd (9) / maddu (10).
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   reset   in   synchronous active-low reset
//   A, B    in   forwarded rs / rt operands (32 bit)
//   MDUOp   in   op code (0 none .. 10 maddu)
//   Start   in   one-cycle pulse for mult/div/madd-class ops
//   Busy    out  operation in flight
//   HI, LO  out  architectural HI / LO
//   MDUOut  out  HI for mfhi, LO for mflo, otherwise 0
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam int unsigned CMAX =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW = $clog2(CMAX + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   thi_q, thi_d;
    logic [31:0]   tlo_q, tlo_d;
    // Divide-by-zero marker: keeps Busy timing but suppresses the commit.
    logic          dz_q, dz_d;

    logic        is_mul;
    logic        is_div;
    logic        is_acc;
    logic        sgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [63:0] acc_sum;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Op class decode
    always_comb begin
        is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
        is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
`ifdef MDU_MADD_EN
        is_acc = (MDUOp == OP_MADD) || (MDUOp == OP_MADDU);
        sgn    = (MDUOp == OP_MULT) || (MDUOp == OP_DIV) ||
                 (MDUOp == OP_MADD);
`else
        is_acc = 1'b0;
        sgn    = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
`endif
    end

    // Datapath: one shared 64-bit multiplier (low 64 bits of the product of
    // sign/zero-extended operands) and a magnitude divider with sign fixup,
    // which gives truncation toward zero and a dividend-signed remainder.
    always_comb begin
        ext_a   = sgn ? {{32{A[31]}}, A} : {32'b0, A};
        ext_b   = sgn ? {{32{B[31]}}, B} : {32'b0, B};
        prod    = ext_a * ext_b;
        acc_sum = {hi_q, lo_q} + prod;

        a_neg = sgn & A[31];
        b_neg = sgn & B[31];
        a_mag = a_neg ? (~A + 32'd1) : A;
        b_mag = b_neg ? (~B + 32'd1) : B;
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        thi_d   = thi_q;
        tlo_d   = tlo_q;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start && (is_mul || is_div || is_acc)) begin
                    state_d = S_RUN;
                    dz_d    = is_div && (B == 32'd0);
                    if (is_div) begin
                        thi_d = rem;
                        tlo_d = quo;
                        cnt_d = CW'(DIV_CYCLES);
                    end else if (is_acc) begin
                        {thi_d, tlo_d} = acc_sum;
                        cnt_d = CW'(MULT_CYCLES);
                    end else begin
                        {thi_d, tlo_d} = prod;
                        cnt_d = CW'(MULT_CYCLES);
                    end
                end else if (MDUOp == OP_MTHI) begin
                    hi_d = A;
                end else if (MDUOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (!dz_q) begin
                        hi_d = thi_q;
                        lo_d = tlo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            thi_q   <= '0;
            tlo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            thi_q   <= thi_d;
            tlo_q   <= tlo_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs
    always_comb begin
        Busy = (state_q == S_RUN);
        HI   = hi_q;
        LO   = lo_q;
        case (MDUOp)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            default: MDUOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized self-checking bench for e_mdu.
// Reference model uses plain 64-bit arithmetic on a software copy of HI/LO.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  MDUOp = '0;
    logic        Start = 1'b0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected HI/LO and Busy length for one issued op.
    function automatic void model(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input bit st,
                                  output logic [31:0] nhi,
                                  output logic [31:0] nlo,
                                  output int ncyc);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        nhi  = m_hi;
        nlo  = m_lo;
        ncyc = 0;
        case (op)
            4'd1: if (st) begin
                p = 64'(sa * sb);
                {nhi, nlo} = p;
                ncyc = 5;
            end
            4'd2: if (st) begin
                p = {32'b0, a} * {32'b0, b};
                {nhi, nlo} = p;
                ncyc = 5;
            end
            4'd3: if (st) begin
                ncyc = 10;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    nlo = q[31:0];
                    nhi = r[31:0];
                end
            end
            4'd4: if (st) begin
                ncyc = 10;
                if (b != 0) begin
                    nlo = a / b;
                    nhi = a % b;
                end
            end
            4'd7: nhi = a;
            4'd8: nlo = a;
`ifdef MDU_MADD_EN
            4'd9: if (st) begin
                p = {m_hi, m_lo} + 64'(sa * sb);
                {nhi, nlo} = p;
                ncyc = 5;
            end
            4'd10: if (st) begin
                p = {m_hi, m_lo} + {32'b0, a} * {32'b0, b};
                {nhi, nlo} = p;
                ncyc = 5;
            end
`endif
            default: ;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit st);
        logic [31:0] ehi, elo;
        int          ncyc, n;
        model(op, a, b, st, ehi, elo, ncyc);
        @(negedge clk);
        A = a;
        B = b;
        MDUOp = op;
        Start = st;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd0;
        n = 0;
        while (Busy && n < 40) begin
            if (n == 0)
                chk({tag, " hold"}, HI, m_hi);
            n++;
            @(negedge clk);
        end
        chk({tag, " busy"}, 32'(n), 32'(ncyc));
        chk({tag, " HI"}, HI, ehi);
        chk({tag, " LO"}, LO, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic check_mf(input string tag);
        MDUOp = 4'd5;
        #1 chk({tag, " mfhi"}, MDUOut, m_hi);
        MDUOp = 4'd6;
        #1 chk({tag, " mflo"}, MDUOut, m_lo);
        MDUOp = 4'd0;
        #1 chk({tag, " none"}, MDUOut, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        int unsigned k;
        k = $urandom_range(0, 7);
        case (k)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'(k + $urandom_range(0, 20));
            3: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [3:0] op;

        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst Busy", 32'(Busy), 32'd0);
        chk("rst HI", HI, 32'd0);
        chk("rst LO", LO, 32'd0);
        chk("rst MDUOut", MDUOut, 32'd0);

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("divu", 4'd4, 32'd7, 32'd2, 1'b1);
        run_op("mthi", 4'd7, 32'h1234_5678, 32'd0, 1'b0);
        check_mf("after mthi");
        run_op("div0", 4'd3, 32'd55, 32'd0, 1'b1);
        run_op("divu0", 4'd4, 32'd55, 32'd0, 1'b1);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // Start during Busy and mtlo during Busy are both ignored.
        @(negedge clk);
        A = 32'd1000;
        B = 32'hFFFF_FFFD;
        MDUOp = 4'd1;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd0;
        n = 0;
        for (int c = 0; c < 40 && Busy; c++) begin
            if (c == 1) begin
                A = 32'd100;
                B = 32'd7;
                MDUOp = 4'd3;
                Start = 1'b1;
            end else if (c == 2) begin
                Start = 1'b0;
                MDUOp = 4'd8;
                A = 32'hDEAD;
            end else begin
                Start = 1'b0;
                MDUOp = 4'd0;
            end
            n++;
            @(negedge clk);
        end
        MDUOp = 4'd0;
        chk("b2b busy", 32'(n), 32'd5);
        chk("b2b HI", HI, 32'hFFFF_FFFF);
        chk("b2b LO", LO, 32'hFFFF_F448);
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_F448;

        // Reset in the middle of a divu discards it.
        @(negedge clk);
        A = 32'd7;
        B = 32'd2;
        MDUOp = 4'd4;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid rst Busy", 32'(Busy), 32'd0);
        chk("mid rst HI", HI, 32'd0);
        chk("mid rst LO", LO, 32'd0);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (Busy)
                n++;
        end
        chk("mid rst no busy", 32'(n), 32'd0);
        chk("mid rst no commit HI", HI, 32'd0);
        chk("mid rst no commit LO", LO, 32'd0);
        m_hi = '0;
        m_lo = '0;

        // madd/maddu, or ignored ops when the feature is compiled out.
        run_op("mthi0", 4'd7, 32'd0, 32'd0, 1'b0);
        run_op("mtlo1s", 4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("madd", 4'd9, 32'd1, 32'd1, 1'b1);
        run_op("maddu", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op("bad op", 4'd13, 32'd3, 32'd3, 1'b1);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    op = 4'($urandom_range(1, 4));
                    run_op("rnd md", op, rnd_val(), rnd_val(), 1'b1);
                end
                4: run_op("rnd mthi", 4'd7, $urandom, rnd_val(), 1'b0);
                5: run_op("rnd mtlo", 4'd8, $urandom, rnd_val(), 1'b0);
                6: begin
                    op = ($urandom_range(0, 1) == 0) ? 4'd0
                         : 4'($urandom_range(11, 15));
                    run_op("rnd none", op, rnd_val(), rnd_val(), 1'b1);
                end
                7: begin
                    op = 4'($urandom_range(9, 10));
                    run_op("rnd madd", op, rnd_val(), rnd_val(), 1'b1);
                end
                8: begin
                    op = 4'($urandom_range(3, 4));
                    run_op("rnd div0", op, rnd_val(), 32'd0, 1'b1);
                end
                default: begin
                    @(negedge clk);
                    check_mf("rnd");
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
